fifo_synch: RTL and testbench

FIFO_SYNCH -- requirements
Module: fifo_synch

---
 rtl/fifo_synch.sv | 119 +++++++++++
 tb/tb_fifo_synch.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fifo_synch.sv
// Synchronous single-clock FIFO with registered read data, occupancy count and registered flags.
// Define FIFO_SYNCH_ERR_FLAGS_EN to add sticky o_overflow / o_underflow outputs.
module fifo_synch #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    output logic                  o_full,
    input  logic                  i_rd_en,
    output logic                  o_empty,
`ifdef FIFO_SYNCH_ERR_FLAGS_EN
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_overflow,
    output logic                  o_underflow
`else
    output logic [DATA_WIDTH-1:0] o_data
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic                  full_q,   full_d;
    logic                  empty_q,  empty_d;
    logic [DATA_WIDTH-1:0] data_q,   data_d;
    logic                  wr_acc;
    logic                  rd_acc;

    // Accept decisions come from registered flags only; no bypass from write to read.
    always_comb begin
        wr_acc   = i_wr_en && !full_q;
        rd_acc   = i_rd_en && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;

        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            data_d   = mem_q[rd_ptr_q];
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            data_q   <= data_d;
        end
    end

    // Storage is deliberately left unreset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_acc && rst_n) begin
            mem_q[wr_ptr_q] <= i_data_in;
        end
    end

    assign o_full  = full_q;
    assign o_empty = empty_q;
    assign o_data  = data_q;

`ifdef FIFO_SYNCH_ERR_FLAGS_EN
    logic overflow_q;
    logic overflow_d;
    logic underflow_q;
    logic underflow_d;

    // Sticky misuse flags: a request rejected by a full/empty FIFO.
    always_comb begin
        overflow_d  = overflow_q  || (i_wr_en && full_q);
        underflow_d = underflow_q || (i_rd_en && empty_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_synch.sv
// Directed bench for fifo_synch (DEPTH=16, DATA_WIDTH=8) with hand-computed expectations.
module tb_fifo_synch;

    logic       clk;
    logic       rst_n;
    logic       i_wr_en;
    logic [7:0] i_data_in;
    logic       o_full;
    logic       i_rd_en;
    logic       o_empty;
    logic [7:0] o_data;
`ifdef FIFO_SYNCH_ERR_FLAGS_EN
    logic       o_overflow;
    logic       o_underflow;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    fifo_synch #(.DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (i_wr_en),
        .i_data_in  (i_data_in),
        .o_full     (o_full),
        .i_rd_en    (i_rd_en),
        .o_empty    (o_empty),
`ifdef FIFO_SYNCH_ERR_FLAGS_EN
        .o_data     (o_data),
        .o_overflow (o_overflow),
        .o_underflow(o_underflow)
`else
        .o_data     (o_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One clock with the given requests; outputs sampled 1 time unit after the edge.
    task automatic cycle(input logic wr, input logic [7:0] d, input logic rd);
        i_wr_en   = wr;
        i_data_in = d;
        i_rd_en   = rd;
        @(posedge clk);
        #1;
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        i_wr_en   = 1'b0;
        i_rd_en   = 1'b0;
        i_data_in = 8'd0;

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", 32'(o_empty), 32'd1);
        check("rst_full",  32'(o_full),  32'd0);
        check("rst_data",  32'(o_data),  32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic ordering
        cycle(1'b1, 8'd10, 1'b0);
        check("after_wr_empty", 32'(o_empty), 32'd0);
        cycle(1'b1, 8'd20, 1'b0);
        cycle(1'b1, 8'd30, 1'b0);
        cycle(1'b0, 8'd0, 1'b1);
        check("rd_first", 32'(o_data), 32'd10);
        cycle(1'b0, 8'd0, 1'b1);
        check("rd_second", 32'(o_data), 32'd20);
        check("one_left_empty", 32'(o_empty), 32'd0);

        // Fill: 30 stored, 0..14 accepted, 15 and 100 dropped
        for (int k = 0; k < 16; k++) begin
            cycle(1'b1, 8'(k), 1'b0);
            if (k == 13) check("full_at_15", 32'(o_full), 32'd0);
        end
        check("full_at_16", 32'(o_full), 32'd1);
        cycle(1'b1, 8'd100, 1'b0);
        check("full_after_drop", 32'(o_full), 32'd1);
        check("data_hold_wr", 32'(o_data), 32'd20);
`ifdef FIFO_SYNCH_ERR_FLAGS_EN
        check("overflow_set", 32'(o_overflow), 32'd1);
        check("underflow_clear", 32'(o_underflow), 32'd0);
`endif

        // Drain: 30, 0..14
        cycle(1'b0, 8'd0, 1'b1);
        check("drain_0", 32'(o_data), 32'd30);
        check("not_full_after_rd", 32'(o_full), 32'd0);
        for (int k = 0; k < 15; k++) begin
            cycle(1'b0, 8'd0, 1'b1);
            check("drain_k", 32'(o_data), 32'(k));
        end
        check("drained_empty", 32'(o_empty), 32'd1);
        cycle(1'b0, 8'd0, 1'b1);
        check("underflow_rd_data", 32'(o_data), 32'd14);
        check("underflow_rd_empty", 32'(o_empty), 32'd1);
`ifdef FIFO_SYNCH_ERR_FLAGS_EN
        check("underflow_set", 32'(o_underflow), 32'd1);
        check("overflow_sticky", 32'(o_overflow), 32'd1);
`endif

        // Simultaneous requests with 5 stored, wrapping the pointers
        for (int k = 0; k < 5; k++) cycle(1'b1, 8'(40 + k), 1'b0);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 8'(50 + k), 1'b1);
            check("simul_data", 32'(o_data), (k < 5) ? 32'(40 + k) : 32'(45 + k));
            check("simul_flags", {30'd0, o_full, o_empty}, 32'd0);
        end
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 8'd0, 1'b1);
            check("simul_tail", 32'(o_data), 32'(65 + k));
        end
        check("simul_end_empty", 32'(o_empty), 32'd1);

        // Simultaneous requests while empty: write only
        cycle(1'b1, 8'd77, 1'b1);
        check("empty_both_data", 32'(o_data), 32'd69);
        check("empty_both_empty", 32'(o_empty), 32'd0);
        cycle(1'b0, 8'd0, 1'b1);
        check("empty_both_rd", 32'(o_data), 32'd77);
        check("empty_both_one", 32'(o_empty), 32'd1);

        // Mid-operation asynchronous reset with 7 stored; write held during reset
        for (int k = 0; k < 7; k++) cycle(1'b1, 8'(200 + k), 1'b0);
        #2;
        rst_n   = 1'b0;
        i_wr_en = 1'b1;
        i_data_in = 8'd99;
        #1;
        check("async_rst_empty", 32'(o_empty), 32'd1);
        check("async_rst_data",  32'(o_data),  32'd0);
`ifdef FIFO_SYNCH_ERR_FLAGS_EN
        check("async_rst_flags", {30'd0, o_overflow, o_underflow}, 32'd0);
`endif
        @(posedge clk);
        #1;
        i_wr_en = 1'b0;
        rst_n   = 1'b1;
        check("rst_ignores_wr", 32'(o_empty), 32'd1);
        cycle(1'b1, 8'd123, 1'b0);
        cycle(1'b0, 8'd0, 1'b1);
        check("resume_data", 32'(o_data), 32'd123);
        check("resume_empty", 32'(o_empty), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
